alarm_ctrl: RTL and testbench
=============================

// Module: alarm_ctrl
// PURPOSE
//  Alarm/chime sequencer feeding the buzzer stage. Compares the running BCD time against
//  three programmable alarm times and drives per-alarm ring enables with timeout and snooze.
//  Also generates the top-of-hour chime request (shouldTick).
//  Sits between the timekeeping/settings logic and the buzzer tone generator.
// PARAMETERS
//  RING_SEC     60   seconds an alarm rings before auto-dismiss (1..255)
//  SNOOZE_SEC   300  seconds of silence after a snooze press (1..4095)
//  MAX_SNOOZE   3    snoozes allowed per trigger; next press dismisses (0..7)
//  CHIME_SEC    1    seconds shouldTick stays high at the top of the hour (1..15)
// PORTS
//  CLK          in   1  system clock
//  RST          in   1  synchronous reset, active-high
//  CP_1Hz       in   1  1 Hz square wave, synchronous to CLK
//  hour         in   8  current hour, BCD 00-23
//  min          in   8  current minute, BCD 00-59
//  sec          in   8  current second, BCD 00-59
//  alm1_hm      in   16 alarm 1 time {hour,min}, BCD; alm2_hm, alm3_hm identical
//  alm1_arm     in   1  alarm 1 armed; alm2_arm, alm3_arm identical
//  button       in   1  debounced snooze/dismiss level (shared by all alarms)
//  alarm1_en    out  1  alarm 1 ringing; alarm2_en, alarm3_en identical
//  shouldTick   out  1  hourly chime request
//  snoozing     out  1  OR of all alarms in SNOOZE state
// BEHAVIOUR
//  - One clock, synchronous active-high reset. On RST all outputs are 0, all FSMs are IDLE
//    and all counters are 0.
//  - tick: 1-cycle strobe in the cycle after a CP_1Hz 0->1 edge (one edge-detect register).
//  - press: 1-cycle strobe on a button 0->1 edge. Holding button high gives one press only.
//  - hour, min, sec and alm*_hm are sampled only in tick cycles.
//  - Per-alarm FSM, 3 independent copies. Each output is registered: it changes in the
//    cycle after the triggering tick or press.
//    IDLE -> RING when tick, arm=1, sec==8'h00 and {hour,min}==almN_hm. Clears ring_cnt
//      and snz_cnt.
//    RING: ring_cnt increments on each tick.
//      Goes to IDLE when ring_cnt reaches RING_SEC-1 on a tick (rings exactly RING_SEC
//      ticks).
//      On press: goes to SNOOZE if snz_cnt<MAX_SNOOZE (snz_cnt++, snooze_cnt=0), else IDLE.
//    SNOOZE: snooze_cnt increments on each tick. When it reaches SNOOZE_SEC-1 on a tick:
//      goes to RING with ring_cnt=0. press in SNOOZE has no effect.
//    Any state -> IDLE in the same cycle arm=0 is seen. Disarm beats press and tick.
//    If a match tick occurs while in RING or SNOOZE, the FSM does not re-trigger.
//  - alarmN_en = (state==RING). snoozing = OR over alarms of (state==SNOOZE).
//  - A single press acts on every alarm in RING in that cycle. Each alarm's snooze
//    decision uses its own snz_cnt.
//  - Chime
//    - Starts on a tick with min==8'h00, sec==8'h00 and no alarm in RING (evaluated
//      after this cycle's trigger).
//    - While running, shouldTick=1 and chime_cnt counts ticks.
//    - shouldTick falls on the tick where chime_cnt reaches CHIME_SEC-1.
//  - Simultaneous alarm trigger and chime: the alarm wins and the chime is suppressed for
//    that hour. An alarm entering RING while the chime runs clears shouldTick the next
//    cycle.
//  - Counter widths: ring_cnt 8b, snooze_cnt 12b, snz_cnt 3b, chime_cnt 4b. No wrap:
//    each counter saturates/clears at its terminal count.
//  - Non-BCD inputs are compared bitwise as given. No validation.
// TESTING
//  1 alm1=07:30 armed, time 07:29:59->07:30:00 -> alarm1_en=1 one cycle after the tick,
//    stays 60 ticks, then 0.
//  2 Ringing, press at ring tick 5 -> alarm1_en=0, snoozing=1. After 300 ticks:
//    alarm1_en=1, snoozing=0.
//  3 Four presses over four rings with MAX_SNOOZE=3 -> first 3 snooze, 4th dismisses to
//    IDLE (snoozing=0).
//  4 alm1 and alm2 both 06:00 -> both enables rise in the same cycle. No shouldTick at
//    06:00:00. One press -> both snooze.
//  5 No alarms, time 08:59:59->09:00:00 -> shouldTick=1 for exactly 1 tick.
//    09:00:00 with alarm at 09:00 -> shouldTick stays 0.
//  6 Deassert alm1_arm mid-RING and mid-SNOOZE -> outputs 0 next cycle. Assert RST
//    mid-RING -> all 0 next cycle, no re-trigger until the next match.

Source files
------------

// File: rtl/alarm_ctrl.sv
// Three-alarm ring/snooze sequencer plus top-of-hour chime request.
// Alarms and chime advance on the 1 Hz tick; snooze/dismiss comes from one shared button.
module alarm_ctrl #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3,
  parameter int CHIME_SEC  = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CP_1Hz,
  input  logic [7:0]  hour,
  input  logic [7:0]  min,
  input  logic [7:0]  sec,
  input  logic [15:0] alm1_hm,
  input  logic [15:0] alm2_hm,
  input  logic [15:0] alm3_hm,
  input  logic        alm1_arm,
  input  logic        alm2_arm,
  input  logic        alm3_arm,
  input  logic        button,
  output logic        alarm1_en,
  output logic        alarm2_en,
  output logic        alarm3_en,
  output logic        shouldTick,
  output logic        snoozing
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RING   = 2'd1;
  localparam logic [1:0] SNOOZE = 2'd2;

  localparam logic [7:0]  RING_LAST   = 8'(RING_SEC - 1);
  localparam logic [11:0] SNOOZE_LAST = 12'(SNOOZE_SEC - 1);
  localparam logic [2:0]  SNZ_MAX     = 3'(MAX_SNOOZE);
  localparam logic [3:0]  CHIME_LAST  = 4'(CHIME_SEC - 1);

  logic        cp_q, btn_q;
  logic        tick, press;
  logic [2:0]  arm;
  logic [15:0] hm [3];

  logic [1:0]  st_q [3];
  logic [1:0]  st_d [3];
  logic [7:0]  ring_q [3];
  logic [7:0]  ring_d [3];
  logic [11:0] snooze_q [3];
  logic [11:0] snooze_d [3];
  logic [2:0]  snz_q [3];
  logic [2:0]  snz_d [3];

  logic        chime_q, chime_d;
  logic [3:0]  chime_cnt_q, chime_cnt_d;
  logic        ring_any;

  assign tick  = CP_1Hz & ~cp_q;
  assign press = button & ~btn_q;
  assign arm   = {alm3_arm, alm2_arm, alm1_arm};
  assign hm[0] = alm1_hm;
  assign hm[1] = alm2_hm;
  assign hm[2] = alm3_hm;

  always_comb begin
    ring_any = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st_d[i]     = st_q[i];
      ring_d[i]   = ring_q[i];
      snooze_d[i] = snooze_q[i];
      snz_d[i]    = snz_q[i];
      if (!arm[i]) begin
        st_d[i]     = IDLE;
        ring_d[i]   = '0;
        snooze_d[i] = '0;
      end else begin
        case (st_q[i])
          IDLE: begin
            if (tick && sec == 8'h00 && {hour, min} == hm[i]) begin
              st_d[i]   = RING;
              ring_d[i] = '0;
              snz_d[i]  = '0;
            end
          end
          RING: begin
            // a press in the same cycle as a tick takes precedence
            if (press) begin
              ring_d[i] = '0;
              if (snz_q[i] < SNZ_MAX) begin
                st_d[i]     = SNOOZE;
                snz_d[i]    = snz_q[i] + 3'd1;
                snooze_d[i] = '0;
              end else begin
                st_d[i] = IDLE;
              end
            end else if (tick) begin
              if (ring_q[i] == RING_LAST) begin
                st_d[i]   = IDLE;
                ring_d[i] = '0;
              end else begin
                ring_d[i] = ring_q[i] + 8'd1;
              end
            end
          end
          SNOOZE: begin
            if (tick) begin
              if (snooze_q[i] == SNOOZE_LAST) begin
                st_d[i]     = RING;
                ring_d[i]   = '0;
                snooze_d[i] = '0;
              end else begin
                snooze_d[i] = snooze_q[i] + 12'd1;
              end
            end
          end
          default: st_d[i] = IDLE;
        endcase
      end
      if (st_d[i] == RING) ring_any = 1'b1;
    end
  end

  // a ringing alarm always silences the chime
  always_comb begin
    chime_d     = chime_q;
    chime_cnt_d = chime_cnt_q;
    if (ring_any) begin
      chime_d     = 1'b0;
      chime_cnt_d = '0;
    end else if (tick) begin
      if (chime_q) begin
        if (chime_cnt_q == CHIME_LAST) begin
          chime_d     = 1'b0;
          chime_cnt_d = '0;
        end else begin
          chime_cnt_d = chime_cnt_q + 4'd1;
        end
      end else if (min == 8'h00 && sec == 8'h00) begin
        chime_d     = 1'b1;
        chime_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cp_q        <= 1'b0;
      btn_q       <= 1'b0;
      chime_q     <= 1'b0;
      chime_cnt_q <= '0;
      for (int i = 0; i < 3; i++) begin
        st_q[i]     <= IDLE;
        ring_q[i]   <= '0;
        snooze_q[i] <= '0;
        snz_q[i]    <= '0;
      end
    end else begin
      cp_q        <= CP_1Hz;
      btn_q       <= button;
      chime_q     <= chime_d;
      chime_cnt_q <= chime_cnt_d;
      for (int i = 0; i < 3; i++) begin
        st_q[i]     <= st_d[i];
        ring_q[i]   <= ring_d[i];
        snooze_q[i] <= snooze_d[i];
        snz_q[i]    <= snz_d[i];
      end
    end
  end

  assign alarm1_en  = (st_q[0] == RING);
  assign alarm2_en  = (st_q[1] == RING);
  assign alarm3_en  = (st_q[2] == RING);
  assign snoozing   = (st_q[0] == SNOOZE) | (st_q[1] == SNOOZE) |
                      (st_q[2] == SNOOZE);
  assign shouldTick = chime_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_alarm_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CP_1Hz = 1'b0;
  logic [7:0]  hour = '0, min = '0, sec = '0;
  logic [15:0] alm1_hm = '0, alm2_hm = '0, alm3_hm = '0;
  logic        alm1_arm = 1'b0, alm2_arm = 1'b0, alm3_arm = 1'b0;
  logic        button = 1'b0;
  logic        alarm1_en, alarm2_en, alarm3_en, shouldTick, snoozing;

  localparam logic [4:0] E0  = 5'b00000;
  localparam logic [4:0] A1  = 5'b10000;
  localparam logic [4:0] A12 = 5'b11000;
  localparam logic [4:0] A3  = 5'b00100;
  localparam logic [4:0] CH  = 5'b00010;
  localparam logic [4:0] SZ  = 5'b00001;

  logic [4:0] q_exp [$];
  string      q_nm  [$];
  int         n_chk = 0;
  int         n_pass = 0;

  alarm_ctrl dut (
    .CLK(CLK), .RST(RST), .CP_1Hz(CP_1Hz),
    .hour(hour), .min(min), .sec(sec),
    .alm1_hm(alm1_hm), .alm2_hm(alm2_hm), .alm3_hm(alm3_hm),
    .alm1_arm(alm1_arm), .alm2_arm(alm2_arm), .alm3_arm(alm3_arm),
    .button(button),
    .alarm1_en(alarm1_en), .alarm2_en(alarm2_en), .alarm3_en(alarm3_en),
    .shouldTick(shouldTick), .snoozing(snoozing)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    logic [4:0] got, e;
    string nm;
    if (q_exp.size() > 0) begin
      e   = q_exp.pop_front();
      nm  = q_nm.pop_front();
      got = {alarm1_en, alarm2_en, alarm3_en, shouldTick, snoozing};
      n_chk++;
      if (got === e) n_pass++;
      else $display("FAIL %s: got {a1,a2,a3,tick,snz}=%b expected %b",
                    nm, got, e);
    end
  end

  task automatic push(input logic [4:0] v, input string nm);
    q_exp.push_back(v);
    q_nm.push_back(nm);
  endtask

  task automatic tk(input logic [7:0] h, input logic [7:0] m,
                    input logic [7:0] s, input logic [4:0] v,
                    input string nm);
    @(posedge CLK); #1;
    hour = h; min = m; sec = s; CP_1Hz = 1'b1;
    @(posedge CLK); #1;
    CP_1Hz = 1'b0;
    push(v, nm);
  endtask

  task automatic filler(input int n, input logic [4:0] v, input string nm);
    for (int i = 0; i < n; i++) tk(8'h12, 8'h34, 8'h56, v, nm);
  endtask

  task automatic press(input logic [4:0] v, input string nm);
    @(posedge CLK); #1;
    button = 1'b1;
    @(posedge CLK); #1;
    push(v, nm);
    button = 1'b0;
  endtask

  task automatic arms(input logic a1, input logic a2, input logic a3,
                      input logic [4:0] v, input string nm);
    @(posedge CLK); #1;
    alm1_arm = a1; alm2_arm = a2; alm3_arm = a3;
    @(posedge CLK); #1;
    push(v, nm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1 push(E0, "reset");
    @(posedge CLK); #1 RST = 1'b0;

    // single alarm rings exactly 60 ticks
    alm1_hm = 16'h0730; alm1_arm = 1'b1;
    tk(8'h07, 8'h29, 8'h59, E0, "t1_pre");
    tk(8'h07, 8'h30, 8'h00, A1, "t1_trig");
    filler(59, A1, "t1_ring_hold");
    tk(8'h12, 8'h34, 8'h56, E0, "t1_timeout");

    // snooze then resume after 300 ticks
    tk(8'h07, 8'h30, 8'h00, A1, "t2_trig");
    filler(5, A1, "t2_ring");
    press(SZ, "t2_snooze1");
    filler(299, SZ, "t2_snz_hold");
    tk(8'h12, 8'h34, 8'h56, A1, "t2_resume");

    // snooze budget: 3 snoozes then dismiss
    press(SZ, "t3_snooze2");
    press(SZ, "t3_press_in_snooze");
    filler(299, SZ, "t3_snz2_hold");
    tk(8'h12, 8'h34, 8'h56, A1, "t3_ring3");
    press(SZ, "t3_snooze3");
    filler(299, SZ, "t3_snz3_hold");
    tk(8'h12, 8'h34, 8'h56, A1, "t3_ring4");
    press(E0, "t3_dismiss");
    tk(8'h12, 8'h34, 8'h56, E0, "t3_stay_idle");

    // two alarms at 06:00, chime suppressed, one press snoozes both
    alm1_hm = 16'h0600; alm2_hm = 16'h0600; alm2_arm = 1'b1;
    tk(8'h05, 8'h59, 8'h59, E0, "t4_pre");
    tk(8'h06, 8'h00, 8'h00, A12, "t4_both");
    tk(8'h06, 8'h00, 8'h01, A12, "t4_no_chime");
    press(SZ, "t4_both_snooze");
    arms(1'b0, 1'b0, 1'b0, E0, "t4_disarm_snz");

    // chime with no alarms, then alarm beats chime
    tk(8'h08, 8'h59, 8'h59, E0, "t5_pre");
    tk(8'h09, 8'h00, 8'h00, CH, "t5_chime");
    tk(8'h09, 8'h00, 8'h01, E0, "t5_chime_end");
    alm1_hm = 16'h0900; alm1_arm = 1'b1;
    tk(8'h08, 8'h59, 8'h59, E0, "t5_pre2");
    tk(8'h09, 8'h00, 8'h00, A1, "t5_alarm_wins");
    tk(8'h09, 8'h00, 8'h01, A1, "t5_no_late_chime");

    // disarm mid-ring and mid-snooze
    arms(1'b0, 1'b0, 1'b0, E0, "t6_disarm_ring");
    alm1_hm = 16'h0700; alm1_arm = 1'b1;
    tk(8'h07, 8'h00, 8'h00, A1, "t6_trig");
    press(SZ, "t6_snz");
    arms(1'b0, 1'b0, 1'b0, E0, "t6_disarm_snz");

    // reset mid-ring, no retrigger until next match
    alm1_arm = 1'b1;
    tk(8'h07, 8'h00, 8'h00, A1, "t6_trig2");
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 push(E0, "t6_rst");
    RST = 1'b0;
    tk(8'h07, 8'h00, 8'h01, E0, "t6_no_retrig");
    tk(8'h07, 8'h00, 8'h00, A1, "t6_retrig");
    arms(1'b0, 1'b0, 1'b0, E0, "t6_disarm2");

    // third alarm channel
    alm3_hm = 16'h2359; alm3_arm = 1'b1;
    tk(8'h23, 8'h58, 8'h59, E0, "t7_pre");
    tk(8'h23, 8'h59, 8'h00, A3, "t7_alm3");
    tk(8'h23, 8'h59, 8'h01, A3, "t7_alm3_hold");
    press(SZ, "t7_alm3_snz");
    arms(1'b0, 1'b0, 1'b0, E0, "t7_disarm");

    for (int i = 0; i < 20 && q_exp.size() > 0; i++) @(posedge CLK);
    if (q_exp.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d entries left, required 0", q_exp.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
